// File: rtl/id_ex_ctrl_stage.sv
// rtl/id_ex_ctrl_stage.sv - RV32I decode stage: ID/EX control register, load-use stall, MDU hold
module id_ex_ctrl_stage #(
  parameter int XLEN        = 32,
  parameter bit ENABLE_M    = 1'b1,
  parameter int MDU_LATENCY = 4
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IF_VALID,
  input  logic [31:0]     IF_IR,
  input  logic [XLEN-1:0] IF_PC,
  input  logic            EX_FLUSH,
  output logic            ID_STALL,
  output logic            MDU_BUSY,
  output logic            EX_VALID,
  output logic [XLEN-1:0] EX_PC,
  output logic [31:0]     EX_IR,
  output logic [4:0]      EX_RS1,
  output logic [4:0]      EX_RS2,
  output logic [4:0]      EX_RD,
  output logic [2:0]      EX_FUNCT3,
  output logic [3:0]      EX_ALU_FUN,
  output logic            EX_ALU_SRCA,
  output logic [1:0]      EX_ALU_SRCB,
  output logic [1:0]      EX_RF_WR_SEL,
  output logic            EX_REG_WRITE,
  output logic            EX_MEM_WRITE,
  output logic            EX_MEM_READ2,
  output logic            EX_BRANCH,
  output logic            EX_JAL,
  output logic            EX_JALR,
  output logic            EX_MDU,
  output logic            EX_ILLEGAL
);

  localparam int CW = $clog2(MDU_LATENCY) + 1;
  localparam logic [CW-1:0] MDU_LOAD = CW'(MDU_LATENCY - 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1, rs2, rd;

  logic [3:0] d_alu_fun;
  logic       d_srca;
  logic [1:0] d_srcb;
  logic [1:0] d_wr_sel;
  logic       d_reg_write, d_mem_write, d_mem_read2;
  logic       d_branch, d_jal, d_jalr, d_mdu, d_illegal;
  logic       uses_rs1, uses_rs2;

  logic [CW-1:0] mdu_cnt;
  logic          mdu_busy;
  logic          load_use;
  logic          kill;

  assign opcode = IF_IR[6:0];
  assign rd     = IF_IR[11:7];
  assign funct3 = IF_IR[14:12];
  assign rs1    = IF_IR[19:15];
  assign rs2    = IF_IR[24:20];
  assign funct7 = IF_IR[31:25];

  // Decode the IF/ID instruction into the control bundle and register-use flags
  always_comb begin
    d_alu_fun   = 4'b0000;
    d_srca      = 1'b0;
    d_srcb      = 2'b00;
    d_wr_sel    = 2'b00;
    d_reg_write = 1'b0;
    d_mem_write = 1'b0;
    d_mem_read2 = 1'b0;
    d_branch    = 1'b0;
    d_jal       = 1'b0;
    d_jalr      = 1'b0;
    d_mdu       = 1'b0;
    d_illegal   = 1'b0;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;
    case (opcode)
      OPC_LUI: begin
        d_alu_fun   = 4'b1001;
        d_srca      = 1'b1;
        d_srcb      = 2'b11;
        d_wr_sel    = 2'b11;
        d_reg_write = 1'b1;
        uses_rs1    = 1'b0;
      end
      OPC_AUIPC: begin
        d_srca      = 1'b1;
        d_srcb      = 2'b11;
        d_wr_sel    = 2'b11;
        d_reg_write = 1'b1;
        uses_rs1    = 1'b0;
      end
      OPC_JAL: begin
        d_jal       = 1'b1;
        d_reg_write = 1'b1;
        uses_rs1    = 1'b0;
      end
      OPC_JALR: begin
        d_jalr      = 1'b1;
        d_srcb      = 2'b01;
        d_reg_write = 1'b1;
      end
      OPC_BRANCH: begin
        d_branch = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        d_srcb      = 2'b01;
        d_wr_sel    = 2'b10;
        d_reg_write = 1'b1;
        d_mem_read2 = 1'b1;
      end
      OPC_STORE: begin
        d_srcb      = 2'b10;
        d_mem_write = 1'b1;
        uses_rs2    = 1'b1;
      end
      OPC_OPIMM: begin
        d_srcb      = 2'b01;
        d_wr_sel    = 2'b11;
        d_reg_write = 1'b1;
        d_alu_fun   = (funct3 == 3'b101) ? {IF_IR[30], funct3} : {1'b0, funct3};
      end
      OPC_OP: begin
        uses_rs2 = 1'b1;
        if (funct7 == 7'b0000001) begin
          // M-extension encodings are only legal when the MDU is built in
          if (ENABLE_M) begin
            d_mdu       = 1'b1;
            d_wr_sel    = 2'b11;
            d_reg_write = 1'b1;
          end else begin
            d_illegal = 1'b1;
          end
        end else begin
          d_alu_fun   = {IF_IR[30], funct3};
          d_wr_sel    = 2'b11;
          d_reg_write = 1'b1;
        end
      end
      OPC_SYSTEM: begin
        d_srcb      = 2'b01;
        d_wr_sel    = 2'b01;
        d_reg_write = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign mdu_busy = (mdu_cnt != '0);
  assign MDU_BUSY = mdu_busy;

  assign load_use = IF_VALID && EX_VALID && EX_MEM_READ2 && (EX_RD != 5'd0) &&
                    ((uses_rs1 && (rs1 == EX_RD)) || (uses_rs2 && (rs2 == EX_RD)));

  // A flush outranks the MDU hold; the hold outranks load-use and empty IF/ID
  assign kill     = !RST_N || EX_FLUSH || (!mdu_busy && (load_use || !IF_VALID));
  assign ID_STALL = RST_N && !EX_FLUSH && (mdu_busy || load_use);

  // ID/EX register: bubble, hold for the MDU, or capture the decoded bundle
  always_ff @(posedge CLK) begin
    if (kill) begin
      EX_VALID     <= 1'b0;
      EX_PC        <= '0;
      EX_IR        <= '0;
      EX_RS1       <= '0;
      EX_RS2       <= '0;
      EX_RD        <= '0;
      EX_FUNCT3    <= '0;
      EX_ALU_FUN   <= '0;
      EX_ALU_SRCA  <= 1'b0;
      EX_ALU_SRCB  <= '0;
      EX_RF_WR_SEL <= '0;
      EX_REG_WRITE <= 1'b0;
      EX_MEM_WRITE <= 1'b0;
      EX_MEM_READ2 <= 1'b0;
      EX_BRANCH    <= 1'b0;
      EX_JAL       <= 1'b0;
      EX_JALR      <= 1'b0;
      EX_MDU       <= 1'b0;
      EX_ILLEGAL   <= 1'b0;
      mdu_cnt      <= '0;
    end else if (mdu_busy) begin
      mdu_cnt <= mdu_cnt - CW'(1);
    end else begin
      EX_VALID     <= 1'b1;
      EX_PC        <= IF_PC;
      EX_IR        <= IF_IR;
      EX_RS1       <= rs1;
      EX_RS2       <= rs2;
      EX_RD        <= rd;
      EX_FUNCT3    <= funct3;
      EX_ALU_FUN   <= d_alu_fun;
      EX_ALU_SRCA  <= d_srca;
      EX_ALU_SRCB  <= d_srcb;
      EX_RF_WR_SEL <= d_wr_sel;
      EX_REG_WRITE <= d_reg_write;
      EX_MEM_WRITE <= d_mem_write;
      EX_MEM_READ2 <= d_mem_read2;
      EX_BRANCH    <= d_branch;
      EX_JAL       <= d_jal;
      EX_JALR      <= d_jalr;
      EX_MDU       <= d_mdu;
      EX_ILLEGAL   <= d_illegal;
      mdu_cnt      <= d_mdu ? MDU_LOAD : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// tb/tb_id_ex_ctrl_stage.sv - self-checking bench for id_ex_ctrl_stage
module tb_id_ex_ctrl_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic        srca;
    logic [1:0]  srcb;
    logic [1:0]  wr_sel;
    logic        rw;
    logic        mw;
    logic        mr;
    logic        br;
    logic        jal;
    logic        jalr;
    logic        mdu;
    logic        ill;
  } ctrl_t;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_ir;
  logic [31:0] if_pc;
  logic        ex_flush;

  ctrl_t act [3];
  logic  stall_o [3];
  logic  busy_o [3];

  ctrl_t m_ex [3];
  int    m_hold [3];

  int  errors = 0;
  int  checks = 0;
  bit  run = 0;

  // instance 0: M on, latency 4; instance 1: M off; instance 2: M on, latency 1
  function automatic bit em_of(int g);
    return g != 1;
  endfunction

  function automatic int lat_of(int g);
    return (g == 2) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gi
    logic stall, busy, valid, srca, rw, mw, mr, br, jal, jalr, mdu, ill;
    logic [31:0] pc, ir;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [1:0]  srcb, wr_sel;

    id_ex_ctrl_stage #(
      .XLEN(32),
      .ENABLE_M(g != 1),
      .MDU_LATENCY((g == 2) ? 1 : 4)
    ) dut (
      .CLK(clk), .RST_N(rst_n), .IF_VALID(if_valid), .IF_IR(if_ir), .IF_PC(if_pc),
      .EX_FLUSH(ex_flush), .ID_STALL(stall), .MDU_BUSY(busy), .EX_VALID(valid),
      .EX_PC(pc), .EX_IR(ir), .EX_RS1(rs1), .EX_RS2(rs2), .EX_RD(rd), .EX_FUNCT3(f3),
      .EX_ALU_FUN(alu), .EX_ALU_SRCA(srca), .EX_ALU_SRCB(srcb), .EX_RF_WR_SEL(wr_sel),
      .EX_REG_WRITE(rw), .EX_MEM_WRITE(mw), .EX_MEM_READ2(mr), .EX_BRANCH(br),
      .EX_JAL(jal), .EX_JALR(jalr), .EX_MDU(mdu), .EX_ILLEGAL(ill)
    );

    assign act[g] = {valid, pc, ir, rs1, rs2, rd, f3, alu, srca, srcb, wr_sel,
                     rw, mw, mr, br, jal, jalr, mdu, ill};
    assign stall_o[g] = stall;
    assign busy_o[g]  = busy;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bundle straight from the opcode table
  function automatic ctrl_t model_decode(logic [31:0] ir, logic [31:0] pc, bit em);
    ctrl_t c = '0;
    c.valid = 1'b1;
    c.pc    = pc;
    c.ir    = ir;
    c.rd    = ir[11:7];
    c.f3    = ir[14:12];
    c.rs1   = ir[19:15];
    c.rs2   = ir[24:20];
    case (ir[6:0])
      7'h37: begin c.alu = 4'h9; c.srca = 1; c.srcb = 2'd3; c.wr_sel = 2'd3; c.rw = 1; end
      7'h17: begin c.srca = 1; c.srcb = 2'd3; c.wr_sel = 2'd3; c.rw = 1; end
      7'h6F: begin c.jal = 1; c.rw = 1; end
      7'h67: begin c.jalr = 1; c.srcb = 2'd1; c.rw = 1; end
      7'h63: c.br = 1;
      7'h03: begin c.srcb = 2'd1; c.wr_sel = 2'd2; c.rw = 1; c.mr = 1; end
      7'h23: begin c.srcb = 2'd2; c.mw = 1; end
      7'h13: begin
        c.srcb = 2'd1; c.wr_sel = 2'd3; c.rw = 1;
        c.alu  = (ir[14:12] == 3'd5) ? {ir[30], 3'd5} : {1'b0, ir[14:12]};
      end
      7'h33: begin
        if (ir[31:25] == 7'd1) begin
          if (em) begin c.mdu = 1; c.wr_sel = 2'd3; c.rw = 1; end
          else c.ill = 1;
        end else begin
          c.alu = {ir[30], ir[14:12]}; c.wr_sel = 2'd3; c.rw = 1;
        end
      end
      7'h73: begin c.srcb = 2'd1; c.wr_sel = 2'd1; c.rw = 1; end
      default: c.ill = 1;
    endcase
    return c;
  endfunction

  function automatic bit model_hazard(ctrl_t ex, logic [31:0] ir, logic v);
    logic [6:0] op = ir[6:0];
    bit u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    bit u2 = (op == 7'h63 || op == 7'h23 || op == 7'h33);
    return v && ex.valid && ex.mr && (ex.rd != 5'd0) &&
           ((u1 && ir[19:15] == ex.rd) || (u2 && ir[24:20] == ex.rd));
  endfunction

  // Bubble fields other than the flags are don't-care
  function automatic ctrl_t care(ctrl_t c);
    if (!c.valid) begin
      c.pc = '0; c.ir = '0; c.rs1 = '0; c.rs2 = '0; c.rd = '0; c.f3 = '0;
      c.alu = '0; c.srca = 1'b0; c.srcb = '0; c.wr_sel = '0;
    end
    return c;
  endfunction

  function automatic bit model_stall(int g);
    return rst_n && !ex_flush && (m_hold[g] != 0 || model_hazard(m_ex[g], if_ir, if_valid));
  endfunction

  // Reference model advances one instruction slot per clock
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (!rst_n || ex_flush) begin
        m_ex[g] = '0; m_hold[g] = 0;
      end else if (m_hold[g] > 0) begin
        m_hold[g] = m_hold[g] - 1;
      end else if (!if_valid || model_hazard(m_ex[g], if_ir, if_valid)) begin
        m_ex[g] = '0;
      end else begin
        m_ex[g]   = model_decode(if_ir, if_pc, em_of(g));
        m_hold[g] = m_ex[g].mdu ? lat_of(g) - 1 : 0;
      end
    end
  end

  // Every cycle: all three DUTs against the model
  always @(negedge clk) begin
    if (run) begin
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (care(act[g]) !== care(m_ex[g])) begin
          errors++;
          $display("FAIL ex_bundle[%0d]: got %h expected %h", g, care(act[g]), care(m_ex[g]));
        end
        checks++;
        if (stall_o[g] !== model_stall(g)) begin
          errors++;
          $display("FAIL id_stall[%0d]: got %b expected %b", g, stall_o[g], model_stall(g));
        end
        checks++;
        if (busy_o[g] !== (m_hold[g] != 0)) begin
          errors++;
          $display("FAIL mdu_busy[%0d]: got %b expected %b", g, busy_o[g], m_hold[g] != 0);
        end
      end
    end
  end

  task automatic chk(string name, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic to_low();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0] opc;
    logic [6:0] f7;
    int k = $urandom_range(0, 12);
    case (k)
      0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;  3: opc = 7'h67;
      4: opc = 7'h63;  5, 6: opc = 7'h03; 7: opc = 7'h23; 8: opc = 7'h13;
      9, 10: opc = 7'h33; 11: opc = 7'h73;
      default: begin
        k = $urandom_range(0, 3);
        opc = (k == 0) ? 7'h7F : (k == 1) ? 7'h0F : (k == 2) ? 7'h00 : 7'h5B;
      end
    endcase
    k = $urandom_range(0, 3);
    f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : (k == 2) ? 7'h01 : 7'($urandom);
    return {f7, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom),
            5'($urandom_range(0, 3)), opc};
  endfunction

  initial begin
    ctrl_t pin;
    rst_n = 0; if_valid = 1; if_ir = 32'h00500093; if_pc = 32'h100; ex_flush = 0;

    pin = model_decode(32'h00500093, 32'h100, 1'b1);
    chk("model_addi_srcb", pin.srcb, 2'b01);
    chk("model_addi_rd", pin.rd, 5'd1);
    pin = model_decode(32'h4050D093, 32'h0, 1'b1);
    chk("model_srai_alu", pin.alu, 4'b1101);

    edge_();
    run = 1;
    to_low();
    chk("rst1_bundle", act[0], '0);
    chk("rst1_stall", stall_o[0], 1'b0);
    chk("rst1_busy", busy_o[0], 1'b0);
    edge_();
    to_low();
    chk("rst2_bundle", act[0], '0);
    chk("rst2_stall", stall_o[0], 1'b0);
    rst_n = 1;
    edge_();
    to_low();
    chk("issue_valid", act[0].valid, 1'b1);
    chk("issue_rd", act[0].rd, 5'd1);
    chk("issue_srcb", act[0].srcb, 2'b01);
    chk("issue_wr_sel", act[0].wr_sel, 2'b11);
    chk("issue_reg_write", act[0].rw, 1'b1);
    chk("issue_pc", act[0].pc, 32'h100);

    if_ir = 32'h0000A283;
    edge_();
    if_ir = 32'h00228333;
    to_low();
    chk("lu_stall", stall_o[0], 1'b1);
    edge_();
    to_low();
    chk("lu_bubble", act[0].valid, 1'b0);
    chk("lu_stall_once", stall_o[0], 1'b0);
    edge_();
    to_low();
    chk("lu_issue_valid", act[0].valid, 1'b1);
    chk("lu_issue_rd", act[0].rd, 5'd6);

    if_ir = 32'h0000A103;
    edge_();
    if_ir = 32'h00228333;
    to_low();
    chk("lu_rs2_stall", stall_o[0], 1'b1);
    edge_();
    edge_();

    if_ir = 32'h0000A003;
    edge_();
    if_ir = 32'h00228333;
    to_low();
    chk("lu_x0_nostall", stall_o[0], 1'b0);
    edge_();
    to_low();
    chk("lu_x0_issue", act[0].rd, 5'd6);

    if_ir = 32'h022081B3; if_pc = 32'h200;
    edge_();
    if_ir = 32'h00500093; if_pc = 32'h204;
    to_low();
    chk("mdu_flag", act[0].mdu, 1'b1);
    chk("mdu_busy0", busy_o[0], 1'b1);
    chk("mdu_stall0", stall_o[0], 1'b1);
    chk("lat1_busy", busy_o[2], 1'b0);
    chk("lat1_stall", stall_o[2], 1'b0);
    chk("noM_illegal", act[1].ill, 1'b1);
    chk("noM_reg_write", act[1].rw, 1'b0);
    for (int i = 1; i < 3; i++) begin
      edge_();
      to_low();
      chk("mdu_hold_flag", act[0].mdu, 1'b1);
      chk("mdu_hold_pc", act[0].pc, 32'h200);
      chk("mdu_hold_busy", busy_o[0], 1'b1);
      chk("mdu_hold_stall", stall_o[0], 1'b1);
    end
    edge_();
    to_low();
    chk("mdu_last_valid", act[0].valid, 1'b1);
    chk("mdu_last_flag", act[0].mdu, 1'b1);
    chk("mdu_last_busy", busy_o[0], 1'b0);
    chk("mdu_last_stall", stall_o[0], 1'b0);
    edge_();
    to_low();
    chk("mdu_next_rd", act[0].rd, 5'd1);
    chk("mdu_next_pc", act[0].pc, 32'h204);
    chk("mdu_next_flag", act[0].mdu, 1'b0);

    if_ir = 32'h0000A283;
    edge_();
    if_ir = 32'h00228333; ex_flush = 1;
    to_low();
    chk("flush_stall", stall_o[0], 1'b0);
    edge_();
    ex_flush = 0;
    to_low();
    chk("flush_bubble", act[0].valid, 1'b0);
    chk("flush_busy", busy_o[0], 1'b0);

    if_ir = 32'h0000007F;
    edge_();
    to_low();
    chk("ill_flag", act[0].ill, 1'b1);
    chk("ill_enables", {act[0].rw, act[0].mw, act[0].mr, act[0].br, act[0].jal, act[0].jalr}, 6'b0);

    if_ir = 32'h022081B3;
    edge_();
    edge_();
    rst_n = 0;
    edge_();
    to_low();
    chk("rst_hold_busy", busy_o[0], 1'b0);
    chk("rst_hold_valid", act[0].valid, 1'b0);
    rst_n = 1;

    for (int n = 0; n < 4000; n++) begin
      edge_();
      rst_n    = ($urandom_range(0, 63) != 0);
      if_valid = ($urandom_range(0, 7) != 0);
      ex_flush = ($urandom_range(0, 15) == 0);
      if_pc    = $urandom & 32'hFFFF_FFFC;
      if_ir    = rand_ir();
    end
    edge_();
    to_low();
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
